// File: rtl/rsa_multi_lane.sv
// rsa_multi_lane: N-lane RSA modexp front-end; jobs are dispatched round-robin to
// identical lanes and retired strictly in acceptance order.
// Ports:
//   clk, rst_n (sync, active-low)
//   i_valid/i_ready + i_msg/i_key/i_modulus  job input
//   o_valid/o_ready + o_out                  result output (msg^key mod modulus)
//   o_busy                                   jobs accepted but not yet retired
//   o_done_cnt                               jobs retired since reset, wrapping

module rsa_lane #(
    parameter int W = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    output logic         i_ready,
    input  logic [W-1:0] i_msg,
    input  logic [W-1:0] i_key,
    input  logic [W-1:0] i_modulus,
    output logic         o_valid,
    input  logic         o_ready,
    output logic [W-1:0] o_out
);
    localparam int CW = $clog2(2 * W) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_R2, S_MBAR, S_XONE, S_SQ, S_MUL, S_FIN, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [W-1:0]  m_q, e_q, msg_q, r2_q, mbar_q, a_q, b_q, res_q;
    logic [W+1:0]  t_q, t_add, t_odd, t_nxt;
    logic [W:0]    r_dbl;
    logic [W-1:0]  r_nxt, mont_res, na, nb;
    logic [CW-1:0] cnt_q, ebit_q;
    logic          r2_last, m_last, e_last, e_msb, mont_run, ld, adv;

    // Bit-serial Montgomery step: t = (t + a0*b [+ m]) / 2; t stays below 2m.
    assign t_add = t_q + (a_q[0] ? {2'b00, b_q} : '0);
    assign t_odd = t_add + (t_add[0] ? {2'b00, m_q} : '0);
    assign t_nxt = t_odd >> 1;
    assign mont_res = (t_nxt >= {2'b00, m_q}) ? W'(t_nxt - {2'b00, m_q})
                                              : t_nxt[W-1:0];

    // R^2 mod m by 2W modular doublings starting from 1.
    assign r_dbl = {r2_q, 1'b0};
    assign r_nxt = (r_dbl >= {1'b0, m_q}) ? W'(r_dbl - {1'b0, m_q})
                                          : r_dbl[W-1:0];

    assign r2_last  = (cnt_q == CW'(2 * W - 1));
    assign m_last   = (cnt_q == CW'(W - 1));
    assign e_last   = (ebit_q == CW'(W - 1));
    assign e_msb    = e_q[W-1];
    assign mont_run = (state_q == S_MBAR) || (state_q == S_XONE) ||
                      (state_q == S_SQ) || (state_q == S_MUL) ||
                      (state_q == S_FIN);

    assign i_ready = (state_q == S_IDLE);
    assign o_valid = (state_q == S_DONE);
    assign o_out   = res_q;

    always_comb begin
        state_d = state_q;
        ld      = 1'b0;
        adv     = 1'b0;
        na      = '0;
        nb      = '0;
        case (state_q)
            S_IDLE: if (i_valid) state_d = S_R2;
            S_R2: begin
                if (r2_last) begin
                    state_d = S_MBAR;
                    ld      = 1'b1;
                    na      = msg_q;
                    nb      = r_nxt;
                end
            end
            S_MBAR: begin
                if (m_last) begin
                    state_d = S_XONE;
                    ld      = 1'b1;
                    na      = W'(1);
                    nb      = r2_q;
                end
            end
            S_XONE: begin
                if (m_last) begin
                    state_d = S_SQ;
                    ld      = 1'b1;
                    na      = mont_res;
                    nb      = mont_res;
                end
            end
            S_SQ: begin
                if (m_last) begin
                    ld = 1'b1;
                    na = mont_res;
                    if (e_msb) begin
                        state_d = S_MUL;
                        nb      = mbar_q;
                    end else begin
                        adv     = 1'b1;
                        state_d = e_last ? S_FIN : S_SQ;
                        nb      = e_last ? W'(1) : mont_res;
                    end
                end
            end
            S_MUL: begin
                if (m_last) begin
                    ld      = 1'b1;
                    adv     = 1'b1;
                    na      = mont_res;
                    state_d = e_last ? S_FIN : S_SQ;
                    nb      = e_last ? W'(1) : mont_res;
                end
            end
            S_FIN:  if (m_last) state_d = S_DONE;
            S_DONE: if (o_ready) state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (state_q == S_IDLE) begin
            if (i_valid) begin
                msg_q  <= i_msg;
                e_q    <= i_key;
                m_q    <= i_modulus;
                r2_q   <= W'(1);
                cnt_q  <= '0;
                ebit_q <= '0;
            end
        end else if (state_q == S_R2) begin
            r2_q  <= r_nxt;
            cnt_q <= cnt_q + CW'(1);
        end else if (mont_run) begin
            t_q   <= t_nxt;
            a_q   <= a_q >> 1;
            cnt_q <= cnt_q + CW'(1);
        end
        if (ld) begin
            a_q   <= na;
            b_q   <= nb;
            t_q   <= '0;
            cnt_q <= '0;
        end
        if (adv) begin
            e_q    <= e_q << 1;
            ebit_q <= ebit_q + CW'(1);
        end
        if (state_q == S_MBAR && m_last) mbar_q <= mont_res;
        if (state_q == S_FIN && m_last)  res_q  <= mont_res;
    end
endmodule

module rsa_multi_lane #(
    parameter int MOD_WIDTH = 256,
    parameter int N_LANE    = 4,
    parameter int CNT_W     = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_valid,
    output logic                      i_ready,
    input  logic [MOD_WIDTH-1:0]      i_msg,
    input  logic [MOD_WIDTH-1:0]      i_key,
    input  logic [MOD_WIDTH-1:0]      i_modulus,
    output logic                      o_valid,
    input  logic                      o_ready,
    output logic [MOD_WIDTH-1:0]      o_out,
    output logic [$clog2(N_LANE):0]   o_busy,
    output logic [CNT_W-1:0]          o_done_cnt
);
    localparam int PW = $clog2(N_LANE);

    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [PW:0]          busy_q;
    logic [CNT_W-1:0]     done_q;
    logic                 ov_q;
    logic [MOD_WIDTH-1:0] out_q;
    logic [N_LANE-1:0]    lane_iv, lane_ir, lane_ov, lane_or;
    logic [MOD_WIDTH-1:0] lane_out [N_LANE];
    logic                 accept, fire, load;

    // Strict round-robin in both directions keeps results in accept order.
    assign i_ready = lane_ir[wr_ptr] && (busy_q < (PW + 1)'(N_LANE));
    assign accept  = i_valid && i_ready && rst_n;
    assign fire    = ov_q && o_ready;
    assign load    = (!ov_q || fire) && lane_ov[rd_ptr] && rst_n;

    for (genvar g = 0; g < N_LANE; g++) begin : g_lane
        assign lane_iv[g] = accept && (wr_ptr == PW'(g));
        assign lane_or[g] = load && (rd_ptr == PW'(g));

        rsa_lane #(.W(MOD_WIDTH)) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_valid   (lane_iv[g]),
            .i_ready   (lane_ir[g]),
            .i_msg     (i_msg),
            .i_key     (i_key),
            .i_modulus (i_modulus),
            .o_valid   (lane_ov[g]),
            .o_ready   (lane_or[g]),
            .o_out     (lane_out[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            busy_q <= '0;
            done_q <= '0;
            ov_q   <= 1'b0;
            out_q  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + PW'(1);
            if (load) begin
                rd_ptr <= rd_ptr + PW'(1);
                out_q  <= lane_out[rd_ptr];
                ov_q   <= 1'b1;
            end else if (fire) begin
                ov_q <= 1'b0;
            end
            if (accept && !fire)      busy_q <= busy_q + (PW + 1)'(1);
            else if (!accept && fire) busy_q <= busy_q - (PW + 1)'(1);
            if (fire) done_q <= done_q + CNT_W'(1);
        end
    end

    assign o_valid    = ov_q;
    assign o_out      = out_q;
    assign o_busy     = busy_q;
    assign o_done_cnt = done_q;
endmodule
